btn_input_debounce: RTL and testbench

- Input-side counterpart to the board's LED drivers: takes raw ECPIX-5 pushbutton pins and produces clean, debounced levels and single-cycle event pulses.
- Event pulses are press, release and long-press.
- Each button has its own synchroniser, debounce counter and hold-timer FSM.
- Sits between the top-level pins and user logic, e.g. an LED pattern sequencer stepped by button events.

---
 rtl/btn_input_debounce.sv | 169 ++++++++++++++++
 tb/tb_btn_input_debounce.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/btn_input_debounce.sv
// Per-button 2-flop synchroniser, debounce counter and RELEASED/PRESSED/HELD hold FSM.
// Define BTN_AUTO_REPEAT_EN to add periodic btn_long repeat pulses while a button stays held.
//
// state      | meaning
// RELEASED   | debounced level is 0, waiting for an accepted press
// PRESSED    | accepted press, hold counter running towards LONG_CYC
// HELD       | long press already signalled, hold counter saturated

module btn_input_debounce #(
    parameter int NUM_BTN      = 2,
    parameter int ACTIVE_LOW   = 1,
    parameter int DEBOUNCE_CYC = 1000000,
    parameter int LONG_CYC     = 100000000,
    parameter int REPEAT_CYC   = 20000000
) (
    input  logic               clk100,
    input  logic               rst_n,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic [NUM_BTN-1:0] btn_long
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYC);
    localparam int HOLD_W = $clog2(LONG_CYC);
    localparam logic [DB_W-1:0]   DB_TC    = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [HOLD_W-1:0] LONG_TC  = HOLD_W'(LONG_CYC - 1);
    localparam logic              SYNC_RST = (ACTIVE_LOW != 0);
`ifdef BTN_AUTO_REPEAT_EN
    localparam int REP_W = $clog2(REPEAT_CYC);
    localparam logic [REP_W-1:0]  REP_TC   = REP_W'(REPEAT_CYC - 1);
`endif

    if (DEBOUNCE_CYC < 2 || LONG_CYC <= DEBOUNCE_CYC || REPEAT_CYC < 2) begin : g_bad_cfg
        $error("btn_input_debounce: illegal DEBOUNCE_CYC/LONG_CYC/REPEAT_CYC combination");
    end

    typedef enum logic [1:0] {
        S_RELEASED = 2'd0,
        S_PRESSED  = 2'd1,
        S_HELD     = 2'd2
    } state_t;

    for (genvar ch = 0; ch < NUM_BTN; ch++) begin : g_ch
        logic [1:0]        sync_q;
        logic              p_sync;
        logic              accept;
        logic [DB_W-1:0]   db_q, db_d;
        logic              level_q, level_d;
        logic              press_q, press_d;
        logic              rel_q, rel_d;
        logic              long_q, long_d;
        state_t            st_q, st_d;
        logic [HOLD_W-1:0] hold_q, hold_d;
`ifdef BTN_AUTO_REPEAT_EN
        logic [REP_W-1:0]  rep_q, rep_d;
`endif

        // Sync flops reset to the idle pin value so reset release never looks like a press.
        assign p_sync = (ACTIVE_LOW != 0) ? ~sync_q[1] : sync_q[1];

        always_ff @(posedge clk100 or negedge rst_n) begin
            if (!rst_n) begin
                sync_q  <= {2{SYNC_RST}};
                db_q    <= '0;
                level_q <= 1'b0;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
                long_q  <= 1'b0;
                st_q    <= S_RELEASED;
                hold_q  <= '0;
`ifdef BTN_AUTO_REPEAT_EN
                rep_q   <= '0;
`endif
            end else begin
                sync_q  <= {sync_q[0], btn_raw[ch]};
                db_q    <= db_d;
                level_q <= level_d;
                press_q <= press_d;
                rel_q   <= rel_d;
                long_q  <= long_d;
                st_q    <= st_d;
                hold_q  <= hold_d;
`ifdef BTN_AUTO_REPEAT_EN
                rep_q   <= rep_d;
`endif
            end
        end

        always_comb begin
            db_d    = '0;
            level_d = level_q;
            accept  = 1'b0;
            if (p_sync != level_q) begin
                if (db_q == DB_TC) begin
                    level_d = p_sync;
                    accept  = 1'b1;
                end else begin
                    db_d = db_q + 1'b1;
                end
            end
        end

        // Release is checked before the long-press terminal count, so it wins a tie.
        always_comb begin
            st_d    = st_q;
            hold_d  = hold_q;
            press_d = 1'b0;
            rel_d   = 1'b0;
            long_d  = 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
            rep_d   = rep_q;
`endif
            case (st_q)
                S_RELEASED: begin
                    if (accept && level_d) begin
                        st_d    = S_PRESSED;
                        hold_d  = '0;
                        press_d = 1'b1;
                    end
                end
                S_PRESSED: begin
                    if (accept && !level_d) begin
                        st_d   = S_RELEASED;
                        hold_d = '0;
                        rel_d  = 1'b1;
                    end else if (hold_q == LONG_TC) begin
                        st_d   = S_HELD;
                        long_d = 1'b1;
`ifdef BTN_AUTO_REPEAT_EN
                        rep_d  = '0;
`endif
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
                S_HELD: begin
                    if (accept && !level_d) begin
                        st_d   = S_RELEASED;
                        hold_d = '0;
                        rel_d  = 1'b1;
`ifdef BTN_AUTO_REPEAT_EN
                        rep_d  = '0;
`endif
                    end
`ifdef BTN_AUTO_REPEAT_EN
                    else if (rep_q == REP_TC) begin
                        long_d = 1'b1;
                        rep_d  = '0;
                    end else begin
                        rep_d = rep_q + 1'b1;
                    end
`endif
                end
                default: begin
                    st_d   = S_RELEASED;
                    hold_d = '0;
                end
            endcase
        end

        assign btn_level[ch]   = level_q;
        assign btn_press[ch]   = press_q;
        assign btn_release[ch] = rel_q;
        assign btn_long[ch]    = long_q;
    end

endmodule

// File: tb/tb_btn_input_debounce.sv
// Self-checking bench for btn_input_debounce: segment table, hand-written corner sequences,
// and random pin activity checked against a window/time-based reference model.

module tb_btn_input_debounce;

    localparam int NB = 2;
    localparam int D  = 8;
    localparam int L  = 40;
    localparam int R  = 10;

    logic          clk100 = 1'b0;
    logic          rst_n  = 1'b0;
    logic [NB-1:0] btn_raw = 2'b11;
    logic [NB-1:0] btn_level, btn_press, btn_release, btn_long;

    btn_input_debounce #(
        .NUM_BTN(NB), .ACTIVE_LOW(1), .DEBOUNCE_CYC(D), .LONG_CYC(L), .REPEAT_CYC(R)
    ) dut (
        .clk100(clk100), .rst_n(rst_n), .btn_raw(btn_raw),
        .btn_level(btn_level), .btn_press(btn_press),
        .btn_release(btn_release), .btn_long(btn_long)
    );

    always #5 clk100 = ~clk100;

    int total = 0;
    int bad   = 0;

    // Reference model: raw pin history since reset release, indexed by cycle.
    logic [1:0] hist [0:8191];
    int         cyc;
    logic [1:0] m_lvl;
    int         m_press_e [NB];
    logic [1:0] e_lvl, e_press, e_rel, e_long;

    int n_press, n_rel, n_long;
    int dut_press_e [NB];

`ifdef BTN_AUTO_REPEAT_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 30)
                $display("FAIL %s: got %b expected %b (edge %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            if (bad <= 30)
                $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit pressed_at(input int ch, input int k);
        if (k < 0) return 1'b0;
        return hist[k][ch] == 1'b0;
    endfunction

    // Level flips at edge e when the pin read as the opposite state for the D cycles that
    // reach the counter through the two sync stages; events are derived from level and
    // the time elapsed since the accepted press.
    task automatic model_edge();
        for (int ch = 0; ch < NB; ch++) begin
            bit all_diff = 1'b1;
            logic prv, nxt;
            for (int k = cyc - D - 2; k <= cyc - 3; k++)
                if (pressed_at(ch, k) == m_lvl[ch]) all_diff = 1'b0;
            prv = m_lvl[ch];
            nxt = all_diff ? ~prv : prv;
            e_press[ch] = !prv && nxt;
            e_rel[ch]   = prv && !nxt;
            e_long[ch]  = 1'b0;
            if (e_press[ch]) m_press_e[ch] = cyc;
            if (prv && nxt) begin
                int d = cyc - m_press_e[ch];
                if (d == L) e_long[ch] = 1'b1;
                if (REP && d > L && ((d - L) % R) == 0) e_long[ch] = 1'b1;
            end
            m_lvl[ch] = nxt;
        end
        e_lvl = m_lvl;
    endtask

    task automatic tick(input logic [1:0] raw);
        btn_raw = raw;
        if (rst_n) begin
            if (cyc >= 8191) begin
                $display("FAIL hist_overflow: got %0d expected below 8191", cyc);
                bad++;
                $display("test done: total=%0d bad=%0d", total, bad);
                $fatal(1, "history overflow");
            end
            hist[cyc] = raw;
        end
        @(posedge clk100);
        if (rst_n) begin
            cyc++;
            model_edge();
        end else begin
            e_lvl = '0; e_press = '0; e_rel = '0; e_long = '0;
        end
        #1;
        check("level",   btn_level,   e_lvl);
        check("press",   btn_press,   e_press);
        check("release", btn_release, e_rel);
        check("long",    btn_long,    e_long);
        n_press += $countones(btn_press);
        n_rel   += $countones(btn_release);
        n_long  += $countones(btn_long);
        for (int ch = 0; ch < NB; ch++)
            if (btn_press[ch]) dut_press_e[ch] = cyc;
    endtask

    task automatic run(input logic [1:0] raw, input int n);
        for (int i = 0; i < n; i++) tick(raw);
    endtask

    task automatic clr_counts();
        n_press = 0; n_rel = 0; n_long = 0;
        for (int ch = 0; ch < NB; ch++) dut_press_e[ch] = -1;
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        m_lvl = '0;
        cyc   = 0;
        e_lvl = '0; e_press = '0; e_rel = '0; e_long = '0;
        #1;
        check("rst_level",   btn_level,   2'b00);
        check("rst_press",   btn_press,   2'b00);
        check("rst_release", btn_release, 2'b00);
        check("rst_long",    btn_long,    2'b00);
        run(btn_raw, n);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [1:0] raw;
        int         ncyc;
        logic [1:0] lvl;
        int         np;
        int         nr;
        int         nl;
    } seg_t;

    seg_t tbl [8];
    int   start;
    logic [1:0] cur;
    int   rem [NB];

    initial begin
        tbl[0] = '{2'b11, 100, 2'b00, 0, 0, 0};
        tbl[1] = '{2'b10,  20, 2'b01, 1, 0, 0};
        tbl[2] = '{2'b11,  20, 2'b00, 0, 1, 0};
        tbl[3] = '{2'b01,  60, 2'b10, 1, 0, REP ? 2 : 1};
        tbl[4] = '{2'b11,  20, 2'b00, 0, 1, 0};
        tbl[5] = '{2'b00,  45, 2'b11, 2, 0, 0};
        tbl[6] = '{2'b10,  20, 2'b01, 0, 1, REP ? 3 : 2};
        tbl[7] = '{2'b11,  20, 2'b00, 0, 1, REP ? 1 : 0};

        #2;
        btn_raw = 2'b11;
        do_reset(5);

        for (int i = 0; i < 8; i++) begin
            clr_counts();
            run(tbl[i].raw, tbl[i].ncyc);
            check("seg_level", btn_level, tbl[i].lvl);
            check_int("seg_press_cnt",   n_press, tbl[i].np);
            check_int("seg_release_cnt", n_rel,   tbl[i].nr);
            check_int("seg_long_cnt",    n_long,  tbl[i].nl);
        end

        // Bounce: 3-cycle runs never qualify; press lands 10 edges after the last toggle.
        clr_counts();
        for (int g = 0; g < 10; g++) run((g % 2 == 0) ? 2'b10 : 2'b11, 3);
        start = cyc;
        run(2'b10, 20);
        check_int("bounce_press_cnt", n_press, 1);
        check_int("bounce_rel_cnt",   n_rel,   0);
        check_int("bounce_press_edge", dut_press_e[0], start + 10);
        run(2'b11, 20);

        // Release accepted on the edge the long pulse would fire.
        clr_counts();
        start = cyc;
        run(2'b01, 40);
        run(2'b11, 30);
        check_int("race_press_cnt", n_press, 1);
        check_int("race_rel_cnt",   n_rel,   1);
        check_int("race_long_cnt",  n_long,  0);
        check_int("race_press_edge", dut_press_e[1], start + 10);

        // Reset while held, button still down at reset release.
        run(2'b10, 30);
        check("midhold_level", btn_level, 2'b01);
        do_reset(3);
        clr_counts();
        run(2'b10, 15);
        check_int("rst_fresh_press_cnt",  n_press, 1);
        check_int("rst_fresh_press_edge", dut_press_e[0], 10);
        run(2'b11, 20);

        // Random pin activity with glitches and long holds.
        cur = 2'b11;
        rem[0] = 0; rem[1] = 0;
        for (int i = 0; i < 3000; i++) begin
            for (int ch = 0; ch < NB; ch++) begin
                if (rem[ch] == 0) begin
                    cur[ch] = 1'($urandom_range(0, 1));
                    rem[ch] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7))
                                                          : int'($urandom_range(8, 120));
                end
                rem[ch]--;
            end
            tick(cur);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
